// File: rtl/dot4_arbiter_pkg.sv
// Shared types and constants for the dot4 arbiter and its core:
// state encoding, operand slot layout and Q8.8 helpers.
package dot4_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEFAULT_NREQ = 3;

  localparam int SLOT_W  = 64;
  localparam int FIELD_W = 16;
  localparam int X_OFF   = 0;
  localparam int Y_OFF   = 16;
  localparam int Z_OFF   = 32;
  localparam int W_OFF   = 48;

  localparam logic [FIELD_W-1:0] Q88_ONE  = 16'h0100;
  localparam logic [FIELD_W-1:0] Q88_ZERO = 16'h0000;

  // Signed Q8.8 multiply; dropping the low 8 bits truncates toward minus infinity.
  function automatic logic [FIELD_W-1:0] q88_mul(input logic [FIELD_W-1:0] a,
                                                 input logic [FIELD_W-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

endpackage

// File: rtl/dot4_arbiter_if.sv
// Requester-side bus of the dot4 arbiter: per-requester request, operand
// slots, ack/done pulses and the shared result.
interface dot4_arbiter_if #(parameter int NREQ = dot4_arbiter_pkg::DEFAULT_NREQ) ();
  import dot4_arbiter_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*SLOT_W-1:0] req_v1;
  logic [NREQ*SLOT_W-1:0] req_v2;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        done;
  logic [FIELD_W-1:0]     result;
  logic                   busy;

  modport master (output req, req_v1, req_v2, input ack, done, result, busy);
  modport slave  (input req, req_v1, req_v2, output ack, done, result, busy);

endinterface

// File: rtl/dot4_arbiter_core.sv
// Sequential Q8.8 dot4 core: one lane per cycle after start, x first and w
// last, with a one-cycle done pulse carrying the wrapped 16-bit sum.
module dot4_core
  import dot4_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SLOT_W-1:0]  op_a,
  input  logic [SLOT_W-1:0]  op_b,
  output logic               done,
  output logic [FIELD_W-1:0] result
);

  logic               running;
  logic [1:0]         lane;
  logic [FIELD_W-1:0] acc;
  logic [FIELD_W-1:0] a_f;
  logic [FIELD_W-1:0] b_f;
  logic [FIELD_W-1:0] prod;

  always_comb begin
    a_f = op_a[X_OFF +: FIELD_W];
    b_f = op_b[X_OFF +: FIELD_W];
    case (lane)
      2'd1: begin a_f = op_a[Y_OFF +: FIELD_W]; b_f = op_b[Y_OFF +: FIELD_W]; end
      2'd2: begin a_f = op_a[Z_OFF +: FIELD_W]; b_f = op_b[Z_OFF +: FIELD_W]; end
      2'd3: begin a_f = op_a[W_OFF +: FIELD_W]; b_f = op_b[W_OFF +: FIELD_W]; end
      default: ;
    endcase
    prod = q88_mul(a_f, b_f);
  end

  // Operands are read lane by lane, so the caller must hold them until done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      running <= 1'b0;
      lane    <= 2'd0;
      acc     <= Q88_ZERO;
      done    <= 1'b0;
      result  <= Q88_ZERO;
    end else begin
      done <= 1'b0;
      if (!running) begin
        if (start) begin
          running <= 1'b1;
          lane    <= 2'd0;
          acc     <= Q88_ZERO;
        end
      end else begin
        acc  <= acc + prod;
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= acc + prod;
        end
      end
    end
  end

endmodule

// File: rtl/dot4_arbiter.sv
// Round-robin arbiter sharing one dot4 core among NREQ requesters; captures
// the winner's operands, runs the core and returns the result with a done pulse.
module dot4_arbiter
  import dot4_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input logic           clk,
  input logic           reset,
  dot4_arbiter_if.slave bus
);

  state_t             state;
  logic [NREQ-1:0]    last_grant;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    winner;
  logic [NREQ-1:0]    ack_q;
  logic [NREQ-1:0]    done_q;
  logic [FIELD_W-1:0] result_q;
  logic               busy_q;
  logic               core_start;
  logic               core_done;
  logic [FIELD_W-1:0] core_result;
  logic [SLOT_W-1:0]  op_a;
  logic [SLOT_W-1:0]  op_b;
  logic [SLOT_W-1:0]  sel_v1;
  logic [SLOT_W-1:0]  sel_v2;

  // Grants are one-hot; search starts just above the previous winner and wraps.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [NREQ-1:0] last);
    logic [NREQ-1:0] pick;
    logic            found;
    int              j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (last[i]) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (i + k) % NREQ;
          if (!found && r[j]) begin
            pick[j] = 1'b1;
            found   = 1'b1;
          end
        end
      end
    end
    return pick;
  endfunction

  always_comb begin
    winner = rr_pick(bus.req, last_grant);
    sel_v1 = '0;
    sel_v2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        sel_v1 = bus.req_v1[i*SLOT_W +: SLOT_W];
        sel_v2 = bus.req_v2[i*SLOT_W +: SLOT_W];
      end
    end
  end

  // Reset leaves the top requester as last winner so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      result_q   <= Q88_ZERO;
      op_a       <= '0;
      op_b       <= '0;
      core_start <= 1'b0;
      grant      <= '0;
      last_grant <= {1'b1, {(NREQ-1){1'b0}}};
    end else begin
      ack_q      <= '0;
      done_q     <= '0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant      <= winner;
            ack_q      <= winner;
            op_a       <= sel_v1;
            op_b       <= sel_v2;
            core_start <= 1'b1;
            busy_q     <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            result_q   <= core_result;
            done_q     <= grant;
            last_grant <= grant;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dot4_core u_dot4 (
    .clk    (clk),
    .reset  (reset),
    .start  (core_start),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (core_done),
    .result (core_result)
  );

  assign bus.ack    = ack_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_dot4_arbiter.sv
// Directed bench for dot4_arbiter with NREQ=3: single ops, sign handling,
// round-robin order, mid-operation reset and operand capture.
module tb_dot4_arbiter;
  import dot4_arbiter_pkg::*;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [63:0] v1_slot [N];
  logic [63:0] v2_slot [N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot4_arbiter_if #(.NREQ(N)) bus ();

  assign bus.req_v1 = {v1_slot[2], v1_slot[1], v1_slot[0]};
  assign bus.req_v2 = {v2_slot[2], v2_slot[1], v2_slot[0]};

  dot4_arbiter #(.NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [63:0] pack4(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z, input logic [15:0] w);
    return {w, z, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_for_done(input int budget, output int cycles,
                               output logic [N-1:0] d, output logic [15:0] r);
    cycles = 0;
    d      = '0;
    r      = '0;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (|bus.done) begin
        cycles = n;
        d      = bus.done;
        r      = bus.result;
        break;
      end
    end
  endtask

  // At most one ack and one done bit may be high in any cycle.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ($countones(bus.ack) > 1 || $countones(bus.done) > 1) begin
        errors++;
        $display("[TB] FAIL onehot ack=%b done=%b (at most one bit each)", bus.ack, bus.done);
      end
    end
  end

  task automatic test_reset();
    v1_slot[0] = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    v2_slot[0] = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    reset   = 1'b0;
    bus.req = 3'b111;
    tick();
    tick();
    checks++; if (bus.ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=000", bus.ack); end
    checks++; if (bus.done !== 3'b000) begin errors++; $display("[TB] FAIL reset_done got=%b exp=000", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result got=%h exp=0000", bus.result); end
    reset   = 1'b1;
    bus.req = '0;
    tick();
    checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req ack=%b busy=%b exp ack=000 busy=0", bus.ack, bus.busy); end
  endtask

  task automatic test_single();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    apply_reset();
    v1_slot[0] = pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    v2_slot[0] = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    bus.req = 3'b001;
    tick();
    checks++; if (bus.ack !== 3'b001 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_ack ack=%b busy=%b exp ack=001 busy=1", bus.ack, bus.busy); end
    bus.req = 3'b000;
    tick();
    checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_ack_pulse ack=%b busy=%b exp ack=000 busy=1", bus.ack, bus.busy); end
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 5 || d !== 3'b001) begin errors++; $display("[TB] FAIL single_done cycles=%0d done=%b exp cycles=5 done=001", cyc, d); end
    checks++; if (r !== 16'h0A00) begin errors++; $display("[TB] FAIL single_result got=%h exp=0a00", r); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_at_done got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 3'b000 || bus.result !== 16'h0A00) begin errors++; $display("[TB] FAIL single_hold done=%b result=%h exp done=000 result=0a00", bus.done, bus.result); end
  endtask

  task automatic test_sign();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    v1_slot[1] = pack4(16'hFF00, 16'h0000, 16'h0000, 16'h0000);
    v2_slot[1] = pack4(16'h0080, 16'h0000, 16'h0000, 16'h0000);
    bus.req = 3'b010;
    tick();
    checks++; if (bus.ack !== 3'b010) begin errors++; $display("[TB] FAIL sign_ack got=%b exp=010", bus.ack); end
    bus.req = 3'b000;
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 6 || d !== 3'b010) begin errors++; $display("[TB] FAIL sign_done cycles=%0d done=%b exp cycles=6 done=010", cyc, d); end
    checks++; if (r !== 16'hFF80) begin errors++; $display("[TB] FAIL sign_result got=%h exp=ff80", r); end
  endtask

  task automatic test_simultaneous();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    v1_slot[0] = pack4(16'h0200, 16'h0100, 16'h0000, 16'h0000);
    v2_slot[0] = pack4(16'h0300, 16'h0100, 16'h0000, 16'h0000);
    v1_slot[2] = pack4(16'h0080, 16'h0080, 16'h0000, 16'h0000);
    v2_slot[2] = pack4(16'h0400, 16'hFE00, 16'h0000, 16'h0000);
    reset   = 1'b0;
    bus.req = 3'b101;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.ack !== 3'b001) begin errors++; $display("[TB] FAIL simul_ack0 got=%b exp=001", bus.ack); end
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 6 || d !== 3'b001 || r !== 16'h0700) begin errors++; $display("[TB] FAIL simul_done0 cycles=%0d done=%b result=%h exp 6/001/0700", cyc, d, r); end
    checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL simul_gap ack=%b busy=%b exp ack=000 busy=0", bus.ack, bus.busy); end
    tick();
    checks++; if (bus.ack !== 3'b100) begin errors++; $display("[TB] FAIL simul_ack2 got=%b exp=100", bus.ack); end
    bus.req = 3'b000;
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 6 || d !== 3'b100 || r !== 16'h0100) begin errors++; $display("[TB] FAIL simul_done2 cycles=%0d done=%b result=%h exp 6/100/0100", cyc, d, r); end
  endtask

  task automatic test_round_robin();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    logic [N-1:0] exp_oh [6];
    logic [15:0]  exp_res [6];
    exp_oh  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_res = '{16'h0700, 16'h0300, 16'h0100, 16'h0700, 16'h0300, 16'h0100};
    v1_slot[1] = pack4(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    v2_slot[1] = pack4(16'h0300, 16'h0000, 16'h0000, 16'h0000);
    reset   = 1'b0;
    bus.req = 3'b111;
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (bus.ack !== exp_oh[k] || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rr_ack%0d ack=%b busy=%b exp ack=%b busy=1", k, bus.ack, bus.busy, exp_oh[k]); end
      if (k == 5) bus.req = 3'b000;
      wait_for_done(20, cyc, d, r);
      checks++; if (cyc != 6 || d !== exp_oh[k] || r !== exp_res[k]) begin errors++; $display("[TB] FAIL rr_done%0d cycles=%0d done=%b result=%h exp 6/%b/%h", k, cyc, d, r, exp_oh[k], exp_res[k]); end
      checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle%0d ack=%b busy=%b exp ack=000 busy=0", k, bus.ack, bus.busy); end
    end
    tick();
    checks++; if (bus.ack !== 3'b000) begin errors++; $display("[TB] FAIL rr_released got=%b exp=000", bus.ack); end
  endtask

  task automatic test_reset_mid_op();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    bus.req = 3'b010;
    tick();
    checks++; if (bus.ack !== 3'b010) begin errors++; $display("[TB] FAIL midrst_ack got=%b exp=010", bus.ack); end
    bus.req = 3'b000;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=1", bus.busy); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 3'b000 || bus.result !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_clear busy=%b done=%b result=%h exp 0/000/0000", bus.busy, bus.done, bus.result); end
    wait_for_done(10, cyc, d, r);
    checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL midrst_no_done got done=%b after %0d cycles exp none", d, cyc); end
    bus.req = 3'b010;
    tick();
    checks++; if (bus.ack !== 3'b010) begin errors++; $display("[TB] FAIL midrst_reack got=%b exp=010", bus.ack); end
    bus.req = 3'b000;
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 6 || d !== 3'b010 || r !== 16'h0300) begin errors++; $display("[TB] FAIL midrst_redo cycles=%0d done=%b result=%h exp 6/010/0300", cyc, d, r); end
  endtask

  task automatic test_operand_stability();
    int cyc; logic [N-1:0] d; logic [15:0] r;
    apply_reset();
    v1_slot[0] = pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    v2_slot[0] = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    bus.req = 3'b001;
    tick();
    checks++; if (bus.ack !== 3'b001) begin errors++; $display("[TB] FAIL stable_ack got=%b exp=001", bus.ack); end
    v1_slot[0] = pack4(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    bus.req = 3'b000;
    wait_for_done(20, cyc, d, r);
    checks++; if (cyc != 6 || d !== 3'b001 || r !== 16'h0A00) begin errors++; $display("[TB] FAIL stable_result cycles=%0d done=%b result=%h exp 6/001/0a00", cyc, d, r); end
  endtask

  initial begin
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      v1_slot[i] = '0;
      v2_slot[i] = '0;
    end
    test_reset();
    test_single();
    test_sign();
    test_simultaneous();
    test_round_robin();
    test_reset_mid_op();
    test_operand_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dot4_arbiter.md
DOT4_ARBITER -- requirements
Module: dot4_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning number of requesters sharing one dot4 unit (2..8).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester level request.
- req_v1  in  NREQ*64  operand vector 1 per requester, Q8.8; slot i = [64*i +: 64], x[15:0], y[31:16], z[47:32], w[63:48].
- req_v2  in  NREQ*64  operand vector 2, same packing.
- ack  out  NREQ  one-cycle pulse: requester's operands captured.
- done  out  NREQ  one-cycle pulse: result valid for that requester.
- result  out  16  signed Q8.8 dot product, valid while any done bit is high.
- busy  out  1  high from grant until the done cycle inclusive.

Function
REQ-003 SHALL instantiate one dot4 core and drive its start, operands and reset; no other block drives that core.
REQ-004 SHALL implement states IDLE and WAIT.
REQ-005 In IDLE with req nonzero at a clock edge, SHALL do all of the following at that edge:
- choose winner g by round-robin from last_grant+1 upward, wrapping modulo NREQ;
- capture slot g of req_v1/req_v2 into operand registers;
- set ack[g]=1, core start=1, busy=1, state=WAIT.
REQ-006 Operand registers SHALL stay constant from capture until the done cycle; the core reads y/z/w operands after start.
REQ-007 Core start SHALL be high for exactly one cycle per grant.
REQ-008 ack SHALL be high for exactly one cycle.
REQ-009 In WAIT, req SHALL be ignored; pending requests are served later.
REQ-010 In WAIT, on the edge where core done=1, SHALL set result=core result, done[g]=1, last_grant=g, busy=0 and state=IDLE; done is a one-cycle pulse.
REQ-011 A new grant SHALL be possible on the edge immediately after the done cycle, giving one idle cycle between consecutive operations.
REQ-012 A requester holding req high through its own done cycle SHALL be treated as a new request and compete in round-robin.
REQ-013 result SHALL hold its last value until the next done.
REQ-014 At most one ack bit and at most one done bit SHALL be high in any cycle.
REQ-015 Arithmetic (Q8.8 products, truncation, wrap) SHALL be entirely the core's; the arbiter SHALL NOT modify result.

Reset
REQ-016 On reset=0 at an edge, SHALL set:
- state=IDLE;
- ack=0, done=0, busy=0, result=0;
- operand registers=0, core start=0;
- last_grant=NREQ-1, so requester 0 wins first.
REQ-017 The core SHALL share the same reset; reset mid-operation SHALL abort it with no done pulse, and the aborted request is lost.

Structure
REQ-018 A shared package SHALL hold:
- state encodings;
- default NREQ;
- operand slot width (64) and field offsets;
- Q8.8 constants ONE=16'h0100 and ZERO.
REQ-019 The only sub-module SHALL be the existing dot4 core, instance name u_dot4; winner select SHALL be a function inside this module.

Verification
REQ-020 Single request: req[0] with v1=(0x0100,0x0200,0x0300,0x0400), v2=all 0x0100 -> ack[0] pulse one edge after req, later done[0] with result=0x0A00, busy low after.
REQ-021 Sign: req[1] with v1=(0xFF00,0,0,0), v2=(0x0080,0,0,0) -> done[1], result=0xFF80 (-0.5).
REQ-022 Simultaneous: req[0] and req[2] held from reset release -> order ack0, done0, ack2, done2; results match each slot; no overlap.
REQ-023 Round-robin: all three req held high for 6 operations -> grant order 0,1,2,0,1,2; exactly one idle cycle after each done.
REQ-024 Reset mid-op: reset=0 for one cycle while busy -> busy=0, no done, result=0; a fresh req[1] then completes normally.
REQ-025 Operand stability: change req_v1 slot 0 on the cycle after ack[0] -> result still reflects the captured operands.
